// File: rtl/leaf_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leaf_tx_arbiter_pkg
// Description : Shared leaf-interface constants and the round-robin
//               selection function used by the leaf transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package leaf_tx_arbiter_pkg;

    // Leaf packet width and the position of its valid bit
    localparam int LEAF_PACKET_BITS = 97;
    localparam int LEAF_VALID_BIT   = LEAF_PACKET_BITS - 1;

    // Widest requester vector the selection function handles
    localparam int RR_MAX_REQ  = 16;
    localparam int RR_IDX_BITS = 4;

    // One-hot pick of the first set request bit, searching upward from
    // last+1 and wrapping modulo n. Bits at or above n must be zero.
    function automatic logic [RR_MAX_REQ-1:0] rr_onehot(
        input logic [RR_MAX_REQ-1:0]  req,
        input logic [RR_IDX_BITS-1:0] last,
        input int                     n
    );
        logic [RR_MAX_REQ-1:0]  pick;
        logic                   found;
        logic [RR_IDX_BITS-1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            idx = RR_IDX_BITS'((int'(last) + k) % n);
            if ((k <= n) && !found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage : leaf_tx_arbiter_pkg
`default_nettype wire

// File: rtl/leaf_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Produces a one-hot pick
//               of the next requester after last_grant and its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import leaf_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req_vld,
    input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
    output logic [NUM_REQ-1:0]         o_pick,
    output logic [$clog2(NUM_REQ)-1:0] o_pick_idx,
    output logic                       o_pick_any
);

    localparam int c_idx_bits = $clog2(NUM_REQ);

    logic [RR_MAX_REQ-1:0]  w_req_ext;
    logic [RR_IDX_BITS-1:0] w_last_ext;
    logic [RR_MAX_REQ-1:0]  w_pick_ext;
    logic                   w_unused_pick_hi;

    // Widen inputs to the fixed width the package function works on
    always_comb begin
        w_req_ext                    = '0;
        w_req_ext[NUM_REQ-1:0]       = i_req_vld;
        w_last_ext                   = '0;
        w_last_ext[c_idx_bits-1:0]   = i_last_grant;
    end

    assign w_pick_ext       = rr_onehot(w_req_ext, w_last_ext, NUM_REQ);
    assign o_pick           = w_pick_ext[NUM_REQ-1:0];
    assign o_pick_any       = |o_pick;
    // Upper bits are always zero because the widened request is zero there
    assign w_unused_pick_hi = &{1'b0, w_pick_ext};

    // Encode the one-hot pick into a requester index
    always_comb begin
        o_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_pick[i]) begin
                o_pick_idx = c_idx_bits'(i);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/leaf_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : leaf_tx_arbiter
// Description : Round-robin arbiter feeding one registered leaf packet slot
//               toward the BFT, with per-requester saturating accept counters.
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_tx_arbiter
    import leaf_tx_arbiter_pkg::*;
#(
    parameter int PACKET_BITS = LEAF_PACKET_BITS,
    parameter int NUM_REQ     = 4,
    parameter int CNT_BITS    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_vld,
    input  logic [NUM_REQ*PACKET_BITS-1:0] req_packet,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [PACKET_BITS-1:0]         dout_leaf_interface2bft,
    input  logic                           ack_bft2interface,
    output logic [$clog2(NUM_REQ)-1:0]     grant_idx,
    output logic [NUM_REQ*CNT_BITS-1:0]    grant_cnt
);

    localparam int                     c_idx_bits   = $clog2(NUM_REQ);
    localparam int                     c_valid_bit  = PACKET_BITS - 1;
    localparam logic [PACKET_BITS-1:0] c_valid_mask = {1'b1, {(PACKET_BITS-1){1'b0}}};
    localparam logic [CNT_BITS-1:0]    c_cnt_max    = '1;

    logic [PACKET_BITS-1:0]               r_dout;
    logic [c_idx_bits-1:0]                r_grant_idx;
    logic [c_idx_bits-1:0]                r_last_grant;
    logic [NUM_REQ-1:0][CNT_BITS-1:0]     r_cnt;

    logic                   w_out_busy;
    logic                   w_free;
    logic                   w_accept;
    logic [NUM_REQ-1:0]     w_pick;
    logic [c_idx_bits-1:0]  w_pick_idx;
    logic                   w_pick_any;
    logic [PACKET_BITS-1:0] w_sel_packet;

    assign w_out_busy = r_dout[c_valid_bit];
    assign w_accept   = w_out_busy && ack_bft2interface;
    // Slot is reusable when empty, or when its packet leaves this cycle
    assign w_free     = !w_out_busy || ack_bft2interface;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req_vld    (req_vld),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick),
        .o_pick_idx   (w_pick_idx),
        .o_pick_any   (w_pick_any)
    );

    // Mux the picked requester's packet slice
    always_comb begin
        w_sel_packet = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_sel_packet = req_packet[i*PACKET_BITS +: PACKET_BITS];
            end
        end
    end

    // Ack only in the cycle the pick is captured, never during reset
    assign req_ack = (w_free && !reset) ? w_pick : '0;

    // Output slot: load the picked packet with valid forced, or empty it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout       <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= c_idx_bits'(NUM_REQ - 1);
        end else if (w_free) begin
            if (w_pick_any) begin
                r_dout       <= w_sel_packet | c_valid_mask;
                r_grant_idx  <= w_pick_idx;
                r_last_grant <= w_pick_idx;
            end else begin
                r_dout <= '0;
            end
        end
    end

    // Count packets accepted by the BFT against the requester that sent them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt[r_grant_idx] != c_cnt_max)) begin
            r_cnt[r_grant_idx] <= r_cnt[r_grant_idx] + CNT_BITS'(1);
        end
    end

    assign dout_leaf_interface2bft = r_dout;
    assign grant_idx               = r_grant_idx;
    assign grant_cnt               = r_cnt;

endmodule : leaf_tx_arbiter
`default_nettype wire

// File: tb/tb_leaf_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_tx_arbiter
// Description : Scoreboard bench for leaf_tx_arbiter (4 requesters, 4-bit
//               counters). Stimulus pushes expected packets; a monitor pops
//               and compares each newly presented output packet.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_tx_arbiter;

    localparam int PB = 97;
    localparam int NR = 4;
    localparam int CB = 4;

    typedef struct packed {
        logic [PB-1:0] pkt;
        logic [1:0]    idx;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_vld;
    logic [NR*PB-1:0] req_packet;
    logic [NR-1:0]    req_ack;
    logic [PB-1:0]    dout;
    logic             ack;
    logic [1:0]       grant_idx;
    logic [NR*CB-1:0] grant_cnt;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   prev_free = 1'b1;

    leaf_tx_arbiter #(
        .PACKET_BITS (PB),
        .NUM_REQ     (NR),
        .CNT_BITS    (CB)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .req_vld                 (req_vld),
        .req_packet              (req_packet),
        .req_ack                 (req_ack),
        .dout_leaf_interface2bft (dout),
        .ack_bft2interface       (ack),
        .grant_idx               (grant_idx),
        .grant_cnt               (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Requester packet with MSB clear and a recognisable payload
    function automatic logic [PB-1:0] pkt(input int i);
        logic [PB-1:0] p;
        p        = '0;
        p[63:0]  = 64'hC0DE_0000_0000_0000 + 64'(i);
        p[80]    = 1'b1;
        return p;
    endfunction

    function automatic logic [PB-1:0] exp_pkt(input int i);
        logic [PB-1:0] p;
        p       = pkt(i);
        p[PB-1] = 1'b1;
        return p;
    endfunction

    task automatic push(input logic [PB-1:0] p, input int i);
        exp_t e;
        e.pkt = p;
        e.idx = 2'(i);
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_packets();
        for (int i = 0; i < NR; i++) req_packet[i*PB +: PB] = pkt(i);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req_vld = '0;
        ack     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset dout", dout, '0);
        chk("reset grant_idx", grant_idx, '0);
        chk("reset grant_cnt", grant_cnt, '0);
        chk("reset req_ack", req_ack, '0);
        reset = 1'b0;
    endtask

    // Monitor: each packet loaded into a freed slot must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_free = 1'b1;
            end else begin
                if (dout[PB-1] && prev_free) begin
                    if (q.size() == 0) begin
                        chk("unexpected packet", dout, '0);
                    end else begin
                        e = q.pop_front();
                        chk("sb packet", dout, e.pkt);
                        chk("sb grant_idx", grant_idx, e.idx);
                    end
                end
                prev_free = !dout[PB-1] || ack;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [PB-1:0] p3;
        reset      = 1'b1;
        req_vld    = '0;
        ack        = 1'b0;
        req_packet = '0;
        #1;
        chk("req_ack in reset", req_ack, '0);
        load_packets();

        // Round robin with everyone requesting and BFT always accepting
        do_reset();
        req_vld = 4'b1111;
        ack     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr req_ack", req_ack, 4'b0001 << (k % 4));
            push(exp_pkt(k % 4), k % 4);
            step();
        end
        req_vld = '0;
        #1;
        chk("rr drain req_ack", req_ack, '0);
        step();
        // Idle: slot empties, counters frozen even with ack high
        chk("idle dout", dout, '0);
        chk("rr counts", grant_cnt, 16'h1112);
        step();
        step();
        chk("idle counts hold", grant_cnt, 16'h1112);
        chk("idle grant_idx hold", grant_idx, 2'd0);

        // Backpressure holds requester 1's packet, then requester 2 follows
        do_reset();
        req_vld = 4'b0110;
        ack     = 1'b0;
        #1;
        chk("bp first req_ack", req_ack, 4'b0010);
        push(exp_pkt(1), 1);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp hold dout", dout, exp_pkt(1));
            chk("bp hold req_ack", req_ack, '0);
            step();
        end
        ack = 1'b1;
        #1;
        chk("bp release req_ack", req_ack, 4'b0100);
        push(exp_pkt(2), 2);
        step();
        req_vld = '0;
        step();
        step();
        chk("bp counts", grant_cnt, 16'h0110);

        // Valid bit forced on a packet whose MSB is clear
        do_reset();
        p3                   = '0;
        p3[63:0]             = 64'h0000_0000_DEAD_BEEF;
        req_packet[3*PB +: PB] = p3;
        req_vld              = 4'b1000;
        ack                  = 1'b1;
        #1;
        chk("msb req_ack", req_ack, 4'b1000);
        p3[PB-1] = 1'b1;
        push(p3, 3);
        step();
        req_vld = '0;
        chk("msb dout", dout, p3);
        step();
        load_packets();

        // Counter saturation: 20 accepts for requester 2
        do_reset();
        req_vld = 4'b0100;
        ack     = 1'b1;
        for (int k = 0; k < 20; k++) begin
            push(exp_pkt(2), 2);
            step();
        end
        req_vld = '0;
        step();
        step();
        chk("sat counts", grant_cnt, 16'h0F00);

        // Asynchronous reset drops a held packet; requester 0 wins afterward
        do_reset();
        req_vld = 4'b0001;
        ack     = 1'b0;
        #1;
        chk("ar first req_ack", req_ack, 4'b0001);
        push(exp_pkt(0), 0);
        step();
        req_vld = '0;
        chk("ar held dout", dout, exp_pkt(0));
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("ar async dout", dout, '0);
        req_vld = 4'b1000;
        #1;
        chk("ar req_ack in reset", req_ack, '0);
        step();
        chk("ar req_ack in reset 2", req_ack, '0);
        reset   = 1'b0;
        req_vld = 4'b1001;
        ack     = 1'b1;
        #1;
        chk("ar pick 0 first", req_ack, 4'b0001);
        push(exp_pkt(0), 0);
        step();
        #1;
        chk("ar pick 3 next", req_ack, 4'b1000);
        push(exp_pkt(3), 3);
        step();
        req_vld = '0;
        step();
        step();
        chk("ar counts", grant_cnt, 16'h1001);

        chk("scoreboard drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_leaf_tx_arbiter
`default_nettype wire

// File: doc/leaf_tx_arbiter.md
LEAF_TX_ARBITER -- requirements
Module: leaf_tx_arbiter

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 97, leaf packet width; bit PACKET_BITS-1 is the valid bit.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of packet requesters (2..16).
REQ-003 SHALL have parameter CNT_BITS, default 16, width of per-requester grant counters.
REQ-004 SHALL have port clk input 1, the single clock.
REQ-005 SHALL have port reset input 1, asynchronous active-high reset.
REQ-006 SHALL have port req_vld input NUM_REQ, where bit i means requester i holds a packet.
REQ-007 SHALL have port req_packet input NUM_REQ*PACKET_BITS, where slice i is requester i's packet.
REQ-008 SHALL have port req_ack output NUM_REQ, a one-cycle pulse meaning requester i's packet was captured.
REQ-009 SHALL have port dout_leaf_interface2bft output PACKET_BITS, the registered packet to the BFT leaf.
REQ-010 SHALL have port ack_bft2interface input 1, meaning the BFT accepts the current packet this cycle.
REQ-011 SHALL have port grant_idx output clog2(NUM_REQ), the index of the requester whose packet is in the output register.
REQ-012 SHALL have port grant_cnt output NUM_REQ*CNT_BITS, giving per-requester accepted-packet counts.

Function
REQ-013 SHALL define out_busy as dout_leaf_interface2bft[PACKET_BITS-1].
REQ-014 SHALL treat the output register as free when out_busy=0, or when out_busy=1 and ack_bft2interface=1 in the same cycle.
REQ-015 SHALL select, when free, the first i with req_vld[i]=1, searching round-robin from last_grant+1 modulo NUM_REQ.
REQ-016 SHALL, on selection, at the next clk edge load req_packet slice i with the MSB forced to 1, set grant_idx=i and set last_grant=i.
REQ-017 SHALL drive req_ack[i] combinationally high in the selection cycle only, with at most one bit set.
REQ-018 SHALL, when free with no req_vld bit set, load dout_leaf_interface2bft with all zeros at the next edge, while last_grant and grant_idx hold.
REQ-019 SHALL hold dout_leaf_interface2bft and grant_idx bit-stable while out_busy=1 and ack_bft2interface=0, with req_ack all zero.
REQ-020 SHALL sustain one packet per cycle back-to-back when ack_bft2interface stays high and requests are present.
REQ-021 SHALL have latency from req_vld to dout valid of 1 cycle when the output register is free.
REQ-022 SHALL ignore ack_bft2interface when out_busy=0, with no counter change.
REQ-023 SHALL increment grant_cnt slice grant_idx by 1 on each cycle with out_busy=1 and ack_bft2interface=1, saturating at 2^CNT_BITS-1.
REQ-024 SHALL allow a requester to change req_packet only after its req_ack; requester packet content is never inspected except for the forced MSB.
REQ-025 SHALL let a requester that deasserts req_vld before its grant simply lose its turn, with no error state.
REQ-026 SHALL guarantee that a continuously requesting requester is granted within NUM_REQ accepted packets.

Reset
REQ-027 SHALL, while reset=1, asynchronously clear dout_leaf_interface2bft to 0, grant_idx to 0, and all grant_cnt slices to 0.
REQ-028 SHALL reset last_grant to NUM_REQ-1, so that requester 0 has first priority.
REQ-029 SHALL force req_ack to 0 while reset=1.
REQ-030 SHALL, on reset during a held packet, drop that packet; the requester is not re-acked.

Structure
REQ-031 SHALL place PACKET_BITS and the valid-bit index in the shared leaf-interface package.
REQ-032 SHALL define the round-robin selection function in that package.
REQ-033 SHALL use one sub-module, rr_pick, which is combinational, takes req_vld and last_grant, and produces a one-hot pick and its index.
REQ-034 SHALL keep all registers in leaf_tx_arbiter.

Verification
REQ-035 SHALL cover round-robin: NUM_REQ=4, req_vld=4'b1111 held, ack_bft2interface=1 -> grant_idx sequence 0,1,2,3,0 on consecutive cycles, with one req_ack per cycle.
REQ-036 SHALL cover backpressure: ack_bft2interface=0 for 5 cycles with req_vld=4'b0110 -> dout stays requester 1's packet with MSB=1, req_ack=0; when ack rises -> requester 2 loads the next cycle.
REQ-037 SHALL cover MSB forcing: requester 3 packet with MSB=0 and payload 64'hDEADBEEF -> dout MSB=1, low 64 bits 64'hDEADBEEF.
REQ-038 SHALL cover idle: req_vld=0 after one accepted packet -> dout=0 the next cycle, grant_cnt unchanged thereafter.
REQ-039 SHALL cover saturation: CNT_BITS=4, 20 accepts for requester 2 -> grant_cnt slice 2 = 15, other slices unchanged.
REQ-040 SHALL cover async reset: reset asserted mid-cycle while out_busy=1 -> dout=0 immediately; after release with req_vld=4'b1000 then 4'b1001 -> requester 0 is granted before requester 3.
